// File: rtl/cam_axi_pkg.sv
// Shared types for the camera-to-AXI frame writer.
// State enum, buffer index type and burst sizing helpers.
package cam_axi_pkg;

  localparam int NUM_BUFS    = 3;
  localparam int BURST_BYTES = 128 * 32 / 8;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_WAIT_DATA,
    S_ISSUE,
    S_WAIT_RESP
  } state_t;

  function automatic int burst_bytes(int len, int dw);
    return len * dw / 8;
  endfunction

  // Ring successor over the triple buffer; out-of-range wraps to 0.
  function automatic buf_idx_t buf_inc(buf_idx_t i);
    return (i >= buf_idx_t'(NUM_BUFS - 1)) ? '0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/frame_buf_sel.sv
// Triple-buffer selector: picks the next buffer to write,
// skipping the one held by the display reader.
// Ports: last_idx (last complete buffer), rd_idx (reader),
//        sel_idx (buffer to write next).
module frame_buf_sel
  import cam_axi_pkg::*;
(
  input  buf_idx_t last_idx,
  input  buf_idx_t rd_idx,
  output buf_idx_t sel_idx
);

  buf_idx_t nxt;
  buf_idx_t nxt2;

  always_comb begin
    nxt     = buf_inc(last_idx);
    nxt2    = buf_inc(nxt);
    sel_idx = (nxt == rd_idx) ? nxt2 : nxt;
  end

endmodule

// File: rtl/frame_wr_sched.sv
// Frame write scheduler: issues one AXI burst command at a
// time into a triple-buffered frame store.
// Ports: clk/rst, sched_en, frame_start, fifo_rd_count,
//   base_addr/frame_stride/rd_buf_idx (buffer config),
//   cmd_valid/cmd_ready/cmd_addr (burst request),
//   resp_valid/resp_err (write response),
//   wr_buf_idx/last_buf_idx/frame_done (frame status),
//   err_short/err_resp/clear_err (sticky errors), busy.
module frame_wr_sched
  import cam_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 128,
  parameter int FRAME_BURSTS   = 1200,
  parameter int RD_COUNT_WIDTH = 11
) (
  input  logic                      m00_axi_aclk,
  input  logic                      cam_data_asy_rst,
  input  logic                      sched_en,
  input  logic                      frame_start,
  input  logic [RD_COUNT_WIDTH-1:0] fifo_rd_count,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     frame_stride,
  input  logic [1:0]                rd_buf_idx,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      resp_valid,
  input  logic                      resp_err,
  output logic [1:0]                wr_buf_idx,
  output logic [1:0]                last_buf_idx,
  output logic                      frame_done,
  output logic                      err_short,
  output logic                      err_resp,
  input  logic                      clear_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(FRAME_BURSTS + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(burst_bytes(BURST_LEN, DATA_WIDTH));
  localparam logic [CNT_W-1:0] LAST_BURST =
    CNT_W'(FRAME_BURSTS - 1);

  state_t                  state;
  state_t                  state_n;
  logic [CNT_W-1:0]        burst_cnt;
  logic                    sof_pend;
  buf_idx_t                sel_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;

  logic data_ok;
  logic pend_eff;
  logic is_last;
  logic stray;
  logic do_sel;
  logic do_resp;
  logic set_short;
  logic fin;
  logic pend_set;

  frame_buf_sel u_sel (
    .last_idx (last_buf_idx),
    .rd_idx   (rd_buf_idx),
    .sel_idx  (sel_idx)
  );

  always_comb begin
    unique case (sel_idx)
      2'd1:    sel_addr = base_addr + frame_stride;
      2'd2:    sel_addr = base_addr + (frame_stride << 1);
      default: sel_addr = base_addr;
    endcase
  end

  assign data_ok  = 32'(fifo_rd_count) >= 32'(BURST_LEN);
  assign is_last  = burst_cnt == LAST_BURST;
  // A pending start is dropped as soon as the scheduler is disabled.
  assign pend_eff = sched_en && (sof_pend || frame_start);
  assign stray    = resp_valid && (state != S_WAIT_RESP);

  always_ff @(posedge m00_axi_aclk or posedge cam_data_asy_rst) begin
    if (cam_data_asy_rst) state <= S_IDLE;
    else                  state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_sel    = 1'b0;
    do_resp   = 1'b0;
    set_short = 1'b0;
    fin       = 1'b0;
    pend_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sched_en) state_n = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (!sched_en) state_n = S_IDLE;
        else if (frame_start) begin
          do_sel  = 1'b1;
          state_n = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (!sched_en) state_n = S_IDLE;
        else if (frame_start) begin
          // Nothing written yet: keep the current buffer as is.
          if (burst_cnt != '0) begin
            set_short = 1'b1;
            do_sel    = 1'b1;
          end
        end else if (data_ok) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        pend_set = frame_start;
        if (cmd_ready) state_n = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        pend_set = frame_start;
        if (resp_valid) begin
          do_resp = 1'b1;
          if (pend_eff) begin
            set_short = 1'b1;
            do_sel    = 1'b1;
            state_n   = S_WAIT_DATA;
          end else begin
            fin = is_last;
            if (!sched_en)   state_n = S_IDLE;
            else if (is_last) state_n = S_WAIT_SOF;
            else             state_n = S_WAIT_DATA;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge cam_data_asy_rst) begin
    if (cam_data_asy_rst) begin
      burst_cnt    <= '0;
      sof_pend     <= 1'b0;
      cmd_addr     <= '0;
      wr_buf_idx   <= 2'd0;
      last_buf_idx <= 2'd2;
      frame_done   <= 1'b0;
      err_short    <= 1'b0;
      err_resp     <= 1'b0;
    end else begin
      frame_done <= fin;
      if (fin) last_buf_idx <= wr_buf_idx;
      // A restart overrides the address advance of its response.
      if (do_sel) begin
        wr_buf_idx <= sel_idx;
        cmd_addr   <= sel_addr;
        burst_cnt  <= '0;
      end else if (do_resp) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
        cmd_addr  <= cmd_addr + STEP;
      end
      if (!sched_en || do_sel) sof_pend <= 1'b0;
      else if (pend_set)       sof_pend <= 1'b1;
      // Set beats clear when both happen together.
      if (set_short)      err_short <= 1'b1;
      else if (clear_err) err_short <= 1'b0;
      if (stray || (do_resp && resp_err)) err_resp <= 1'b1;
      else if (clear_err)                 err_resp <= 1'b0;
    end
  end

  assign cmd_valid = state == S_ISSUE;
  assign busy      = state != S_IDLE;

endmodule

// File: tb/tb_frame_wr_sched.sv
// Directed self-checking bench for frame_wr_sched with a
// one-deep AXI write master model and command logger.
module tb_frame_wr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sched_en = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] fifo_rd_count = '0;
  logic [31:0] base_addr = 32'h1000_0000;
  logic [31:0] frame_stride = 32'h0010_0000;
  logic [1:0]  rd_buf_idx = 2'd1;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic        resp_valid = 1'b0;
  logic        resp_err = 1'b0;
  logic [1:0]  wr_buf_idx;
  logic [1:0]  last_buf_idx;
  logic        frame_done;
  logic        err_short;
  logic        err_resp;
  logic        clear_err = 1'b0;
  logic        busy;

  frame_wr_sched dut (
    .m00_axi_aclk     (clk),
    .cam_data_asy_rst (rst),
    .sched_en         (sched_en),
    .frame_start      (frame_start),
    .fifo_rd_count    (fifo_rd_count),
    .base_addr        (base_addr),
    .frame_stride     (frame_stride),
    .rd_buf_idx       (rd_buf_idx),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .wr_buf_idx       (wr_buf_idx),
    .last_buf_idx     (last_buf_idx),
    .frame_done       (frame_done),
    .err_short        (err_short),
    .err_resp         (err_resp),
    .clear_err        (clear_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] cmd_log [0:8191];
  int cmd_cnt = 0;
  int resp_n = 0;
  int fd_cnt = 0;
  int viol = 0;
  int outst = 0;
  int err_at = -1;
  int stray_seq = 0;
  int stray_done = 0;
  bit hs_pend = 1'b0;
  bit hold_resp = 1'b0;

  always @(negedge clk) begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    if (frame_done) fd_cnt++;
    if (rst) begin
      hs_pend = 1'b0;
      outst   = 0;
    end else begin
      if (cmd_valid && outst > 0) viol++;
      if (hs_pend && !hold_resp) begin
        resp_valid = 1'b1;
        resp_err   = (resp_n == err_at);
        resp_n++;
        hs_pend = 1'b0;
        outst--;
      end else if (stray_seq != stray_done) begin
        resp_valid = 1'b1;
        stray_done = stray_seq;
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_cnt < 8192) cmd_log[cmd_cnt] = cmd_addr;
        cmd_cnt++;
        hs_pend = 1'b1;
        outst++;
      end
    end
  end

  task automatic pulse_sof();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
  endtask

  task automatic wait_cmds(input string tag, input int n,
                           input int lim);
    for (int i = 0; i < lim && cmd_cnt < n; i++)
      @(negedge clk);
    @(negedge clk);
    check(tag, 32'(cmd_cnt >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0, s, e, bad;
    logic [31:0] a0;

    repeat (3) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_wr_buf", wr_buf_idx, 0);
    check("rst_last_buf", last_buf_idx, 2);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_resp", err_resp, 0);
    check("rst_busy", busy, 0);

    // Full frame into buffer 0.
    @(negedge clk);
    rst = 1'b0;
    sched_en = 1'b1;
    fifo_rd_count = 11'd128;
    repeat (2) @(negedge clk);
    check("s1_busy", busy, 1);
    c0 = cmd_cnt;
    f0 = fd_cnt;
    pulse_sof();
    for (int i = 0; i < 6000 && fd_cnt <= f0; i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
    check("s1_fd_cnt", fd_cnt - f0, 1);
    check("s1_cmds", cmd_cnt - c0, 1200);
    check("s1_first", cmd_log[c0], 32'h1000_0000);
    check("s1_last", cmd_log[c0 + 1199], 32'h1009_5E00);
    bad = 0;
    for (int i = 1; i < 1200; i++)
      if (cmd_log[c0 + i] !== cmd_log[c0 + i - 1] + 32'h200)
        bad++;
    check("s1_steps", bad, 0);
    check("s1_last_buf", last_buf_idx, 0);
    check("s1_err_short", err_short, 0);
    check("s1_err_resp", err_resp, 0);

    // Reader on 1, last 0: skip to buffer 2.
    c0 = cmd_cnt;
    pulse_sof();
    wait_cmds("s2_wait", c0 + 5, 100);
    fifo_rd_count = 11'd0;
    repeat (6) @(negedge clk);
    check("s2_first", cmd_log[c0], 32'h1020_0000);
    check("s2_wr_buf", wr_buf_idx, 2);

    // Truncate after 5 bursts in WAIT_DATA.
    rd_buf_idx = 2'd0;
    f0 = fd_cnt;
    check("s3_pre_short", err_short, 0);
    pulse_sof();
    check("s3_err_short", err_short, 1);
    check("s3_wr_buf", wr_buf_idx, 1);
    check("s3_cmd_addr", cmd_addr, 32'h1010_0000);
    c0 = cmd_cnt;
    fifo_rd_count = 11'd128;
    wait_cmds("s3_wait", c0 + 1, 20);
    check("s3_restart", cmd_log[c0], 32'h1010_0000);
    check("s3_no_fd", fd_cnt, f0);

    // Start arrives while the response is held.
    pulse_clr();
    check("s4_clr_short", err_short, 0);
    rd_buf_idx = 2'd1;
    hold_resp = 1'b1;
    repeat (5) @(negedge clk);
    check("s4_held_valid", cmd_valid, 0);
    check("s4_outst", outst, 1);
    c0 = cmd_cnt;
    pulse_sof();
    check("s4_no_issue", cmd_cnt, c0);
    hold_resp = 1'b0;
    wait_cmds("s4_wait", c0 + 1, 20);
    check("s4_restart", cmd_log[c0], 32'h1020_0000);
    check("s4_err_short", err_short, 1);
    check("s4_err_resp", err_resp, 0);
    check("s4_wr_buf", wr_buf_idx, 2);
    check("s4_no_fd", fd_cnt, f0);

    // Error response mid-frame, then a stray response.
    pulse_clr();
    check("s5_clr_resp", err_resp, 0);
    s = cmd_cnt;
    err_at = resp_n + 2;
    for (int i = 0; i < 50 && resp_n < err_at + 3; i++)
      @(negedge clk);
    @(negedge clk);
    check("s5_err_resp", err_resp, 1);
    e = cmd_cnt;
    check("s5_span", cmd_log[e - 1] - cmd_log[s],
          32'(e - 1 - s) * 32'h200);
    pulse_clr();
    check("s5_clr2", err_resp, 0);
    fifo_rd_count = 11'd0;
    repeat (4) @(negedge clk);
    a0 = cmd_addr;
    stray_seq++;
    repeat (3) @(negedge clk);
    check("s5_stray_flag", err_resp, 1);
    check("s5_stray_addr", cmd_addr, a0);
    c0 = cmd_cnt;
    fifo_rd_count = 11'd128;
    wait_cmds("s5_wait", c0 + 1, 20);
    check("s5_next_addr", cmd_log[c0], a0);

    // Clear coincident with a new short-frame error.
    fifo_rd_count = 11'd0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    clear_err = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    clear_err = 1'b0;
    check("s5_clr_coincide", err_short, 1);
    check("s5_clr_other", err_resp, 0);

    // Reset while a command is presented.
    cmd_ready = 1'b0;
    fifo_rd_count = 11'd128;
    repeat (3) @(negedge clk);
    check("s6_pre_valid", cmd_valid, 1);
    rst = 1'b1;
    #1;
    check("s6_cmd_valid", cmd_valid, 0);
    check("s6_busy", busy, 0);
    check("s6_last_buf", last_buf_idx, 2);
    check("s6_wr_buf", wr_buf_idx, 0);
    check("s6_cmd_addr", cmd_addr, 0);
    check("s6_err_short", err_short, 0);
    @(negedge clk);
    rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("s6_idle_noissue", cmd_valid, 0);
    check("one_outstanding", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_wr_sched.md
FRAME_WR_SCHED -- requirements
Module: frame_wr_sched

Interface
REQ-001 The block SHALL expose these parameters:
  ADDR_WIDTH, 32, AXI address width.
  DATA_WIDTH, 32, AXI data width in bits.
  BURST_LEN, 128, beats per write burst.
  FRAME_BURSTS, 1200, bursts per frame (640x480x16 bpp).
  RD_COUNT_WIDTH, 11, width of the FIFO read-side level.
REQ-002 The block SHALL have these ports, clock and reset first:
  m00_axi_aclk  in  1  sole clock.
  cam_data_asy_rst  in  1  reset, asynchronous, active-high.
  sched_en  in  1  scheduler enable (level).
  frame_start  in  1  one-cycle start-of-frame pulse (vsync, already synchronised).
  fifo_rd_count  in  RD_COUNT_WIDTH  words available in the pixel FIFO.
  base_addr  in  ADDR_WIDTH  address of buffer 0.
  frame_stride  in  ADDR_WIDTH  byte distance between buffers.
  rd_buf_idx  in  2  buffer currently held by the display reader (0..2).
  cmd_valid  out  1  burst request to the AXI master.
  cmd_ready  in  1  master accepts the request.
  cmd_addr  out  ADDR_WIDTH  burst start address.
  resp_valid  in  1  write response pulse from the master.
  resp_err  in  1  response was not OKAY (qualified by resp_valid).
  wr_buf_idx  out  2  buffer being written.
  last_buf_idx  out  2  last fully written buffer.
  frame_done  out  1  one-cycle pulse on frame completion.
  err_short  out  1  sticky flag: a frame was truncated.
  err_resp  out  1  sticky flag: bad or unexpected response.
  clear_err  in  1  clears both sticky flags.
  busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_SOF, WAIT_DATA, ISSUE and WAIT_RESP.
REQ-004 IDLE SHALL move to WAIT_SOF while sched_en=1.
REQ-005 WAIT_SOF on frame_start SHALL:
  - select a buffer per REQ-012;
  - set burst_cnt=0;
  - set cmd_addr = base_addr + idx*frame_stride, computed mod 2^ADDR_WIDTH;
  - go to WAIT_DATA.
REQ-006 WAIT_DATA SHALL go to ISSUE in the cycle after fifo_rd_count >= BURST_LEN.
REQ-007 ISSUE SHALL hold cmd_valid=1 and keep cmd_addr stable until cmd_valid&&cmd_ready, then go to WAIT_RESP with cmd_valid=0 in the next cycle.
REQ-008 Outstanding bursts SHALL never exceed one.
REQ-009 WAIT_RESP on resp_valid SHALL:
  - increment burst_cnt;
  - advance cmd_addr by BURST_LEN*DATA_WIDTH/8;
  - set err_resp if resp_err=1.
REQ-010 If the completed burst was burst FRAME_BURSTS-1, the block SHALL pulse frame_done for one cycle, load last_buf_idx from wr_buf_idx and go to WAIT_SOF; otherwise it SHALL go to WAIT_DATA.
REQ-011 frame_start SHALL be handled by state:
  - WAIT_DATA with burst_cnt>0: set err_short and restart immediately per REQ-005.
  - WAIT_DATA with burst_cnt=0: restart on the same buffer, no error.
  - ISSUE or WAIT_RESP: latch sof_pend; after the response, set err_short and restart per REQ-005, suppressing frame_done.
REQ-012 Buffer selection SHALL be next=(last_buf_idx+1) mod 3; if next equals rd_buf_idx, it SHALL use (last_buf_idx+2) mod 3 instead.
REQ-013 On sched_en=0:
  - IDLE, WAIT_SOF or WAIT_DATA: enter IDLE next cycle.
  - ISSUE or WAIT_RESP: complete the handshake and response, then enter IDLE.
  - sof_pend SHALL be discarded.
REQ-014 resp_valid outside WAIT_RESP SHALL be ignored for counting and SHALL set err_resp.
REQ-015 Sticky flags SHALL set, not clear, when a set condition and clear_err occur in the same cycle.
REQ-016 base_addr and frame_stride SHALL be sampled only at buffer selection.

Reset
REQ-017 While cam_data_asy_rst=1, the block SHALL asynchronously force:
  - state=IDLE, burst_cnt=0, sof_pend=0;
  - cmd_valid=0, cmd_addr=0;
  - wr_buf_idx=0, last_buf_idx=2;
  - frame_done=0, err_short=0, err_resp=0, busy=0.
REQ-018 Reset asserted mid-burst SHALL drop cmd_valid immediately, and no residual state SHALL survive.

Structure
REQ-019 Package cam_axi_pkg SHALL hold the state enum, the buffer-index type, NUM_BUFS=3 and BURST_BYTES.
REQ-020 Buffer selection SHALL be a combinational sub-module, frame_buf_sel.

Verification
REQ-021 The bench SHALL cover these scenarios:
  - Reset, sched_en=1, frame_start, fifo_rd_count=128 held, ready/resp immediate, base=0x1000_0000, stride=0x0010_0000 -> 1200 commands from 0x1000_0000 in 0x200 steps, last at 0x1009_5E00, frame_done once, last_buf_idx=0.
  - rd_buf_idx=1 with last_buf_idx=0 -> next frame writes buffer 2 at 0x1020_0000.
  - frame_start after 5 bursts in WAIT_DATA -> err_short=1, cmd_addr restarts at the new buffer base, no frame_done.
  - frame_start during WAIT_RESP -> response consumed, then restart; exactly one command outstanding at all times.
  - resp_err=1 on burst 3 and a stray resp_valid in WAIT_DATA -> err_resp=1 with counting unaffected; clear_err coincident with a new error -> flag stays 1.
  - Reset asserted while cmd_valid=1 -> cmd_valid=0 the same cycle, state IDLE, last_buf_idx=2.
